gearbox_tx_param: RTL and testbench

//  Parametrised single-clock TX gearbox: repacks CH lanes of IN_W-bit words into OUT_W-bit

---
 rtl/gearbox_tx_param.sv | 66 ++++++
 tb/tb_gearbox_tx_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gearbox_tx_param.sv
// gearbox_tx_param: repacks CH lanes of IN_W-bit words into OUT_W-bit words.
// One shared fill count keeps every lane word-aligned; flush drops all buffered bits.
module gearbox_tx_param #(
    parameter int CH        = 1,
    parameter int IN_W      = 10,
    parameter int OUT_W     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                                 pclk,
    input  logic                                 txrst,
    input  logic                                 flush,
    input  logic [CH*IN_W-1:0]                   in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [CH*OUT_W-1:0]                  out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(IN_W+OUT_W+1)-1:0]      fill
);
    localparam int BUF_W = IN_W + OUT_W;
    localparam int CW    = $clog2(BUF_W + 1);

    logic [CW-1:0]    cnt_q, cnt_d, c1;
    logic [BUF_W-1:0] sr_q [CH];
    logic [BUF_W-1:0] sr_d [CH];
    logic [IN_W-1:0]  word;
    logic             push, pop;

    assign in_ready  = cnt_q <= CW'(BUF_W - IN_W);
    assign out_valid = cnt_q >= CW'(OUT_W);
    assign fill      = cnt_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Pop shifts the oldest OUT_W bits away first, then a pushed word lands just above what remains
    always_comb begin
        c1    = cnt_q - (pop ? CW'(OUT_W) : '0);
        cnt_d = flush ? '0 : c1 + (push ? CW'(IN_W) : '0);
        word  = '0;
        for (int k = 0; k < CH; k++) begin
            for (int i = 0; i < IN_W; i++)
                word[i] = in_data[k*IN_W + (MSB_FIRST ? IN_W-1-i : i)];
            sr_d[k] = flush ? '0 : ((pop ? sr_q[k] >> OUT_W : sr_q[k]) |
                                    (push ? BUF_W'(word) << c1 : '0));
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < CH; k++)
            for (int i = 0; i < OUT_W; i++)
                out_data[k*OUT_W + i] = sr_q[k][MSB_FIRST ? OUT_W-1-i : i];
    end

    always_ff @(posedge pclk or posedge txrst) begin
        if (txrst) begin
            cnt_q <= '0;
            for (int k = 0; k < CH; k++) sr_q[k] <= '0;
        end else begin
            cnt_q <= cnt_d;
            for (int k = 0; k < CH; k++) sr_q[k] <= sr_d[k];
        end
    end

    assert property (@(posedge pclk) disable iff (txrst) cnt_q <= CW'(BUF_W));
endmodule

// File: tb/tb_gearbox_tx_param.sv
// tb_gearbox_tx_param: directed checks of the TX gearbox in several lane/width configurations.
module tb_gearbox_tx_param;
    logic pclk = 1'b0;
    logic txrst;
    always #5 pclk = ~pclk;

    int n_chk = 0;
    int n_fail = 0;

    logic [9:0] a_in, b_in;
    logic [29:0] c_in;
    logic [7:0] d_in;
    logic [2:0] e_in;
    logic a_iv, a_ir, a_ov, a_or, a_fl;
    logic b_iv, b_ir, b_ov, b_or;
    logic c_iv, c_ir, c_ov, c_or;
    logic d_iv, d_ir, d_ov, d_or;
    logic e_iv, e_ir, e_ov, e_or;
    logic [3:0] a_od, b_od;
    logic [11:0] c_od;
    logic [7:0] d_od;
    logic [6:0] e_od;
    logic [3:0] a_fill, b_fill, c_fill, e_fill;
    logic [4:0] d_fill;

    logic [63:0] a_win[$], a_exp[$], b_win[$], b_exp[$];
    logic [63:0] d_win[$], d_exp[$], e_win[$], e_exp[$];
    bit cq[3][$];
    int c_push, c_pop;

    gearbox_tx_param #(.CH(1), .IN_W(10), .OUT_W(4), .MSB_FIRST(1'b0)) u_a (
        .pclk(pclk), .txrst(txrst), .flush(a_fl), .in_data(a_in), .in_valid(a_iv),
        .in_ready(a_ir), .out_data(a_od), .out_valid(a_ov), .out_ready(a_or), .fill(a_fill));
    gearbox_tx_param #(.CH(1), .IN_W(10), .OUT_W(4), .MSB_FIRST(1'b1)) u_b (
        .pclk(pclk), .txrst(txrst), .flush(1'b0), .in_data(b_in), .in_valid(b_iv),
        .in_ready(b_ir), .out_data(b_od), .out_valid(b_ov), .out_ready(b_or), .fill(b_fill));
    gearbox_tx_param #(.CH(3), .IN_W(10), .OUT_W(4), .MSB_FIRST(1'b0)) u_c (
        .pclk(pclk), .txrst(txrst), .flush(1'b0), .in_data(c_in), .in_valid(c_iv),
        .in_ready(c_ir), .out_data(c_od), .out_valid(c_ov), .out_ready(c_or), .fill(c_fill));
    gearbox_tx_param #(.CH(1), .IN_W(8), .OUT_W(8), .MSB_FIRST(1'b0)) u_d (
        .pclk(pclk), .txrst(txrst), .flush(1'b0), .in_data(d_in), .in_valid(d_iv),
        .in_ready(d_ir), .out_data(d_od), .out_valid(d_ov), .out_ready(d_or), .fill(d_fill));
    gearbox_tx_param #(.CH(1), .IN_W(3), .OUT_W(7), .MSB_FIRST(1'b0)) u_e (
        .pclk(pclk), .txrst(txrst), .flush(1'b0), .in_data(e_in), .in_valid(e_iv),
        .in_ready(e_ir), .out_data(e_od), .out_valid(e_ov), .out_ready(e_or), .fill(e_fill));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // One clock of handshake bookkeeping for every instance; outputs are sampled 1 unit after the edge
    task automatic cycle(input int n);
        logic [3:0] w;
        for (int j = 0; j < n; j++) begin
            a_iv = a_win.size() > 0; a_in = a_iv ? a_win[0][9:0] : '0;
            b_iv = b_win.size() > 0; b_in = b_iv ? b_win[0][9:0] : '0;
            d_iv = d_win.size() > 0; d_in = d_iv ? d_win[0][7:0] : '0;
            e_iv = e_win.size() > 0; e_in = e_iv ? e_win[0][2:0] : '0;
            c_in = 30'($urandom());
            if (a_ov && a_or) check("a_out", 64'(a_od), a_exp.size() > 0 ? a_exp.pop_front() : 64'hDEAD);
            if (b_ov && b_or) check("b_out", 64'(b_od), b_exp.size() > 0 ? b_exp.pop_front() : 64'hDEAD);
            if (d_ov && d_or) check("d_out", 64'(d_od), d_exp.size() > 0 ? d_exp.pop_front() : 64'hDEAD);
            if (e_ov && e_or) check("e_out", 64'(e_od), e_exp.size() > 0 ? e_exp.pop_front() : 64'hDEAD);
            if (a_iv && a_ir) void'(a_win.pop_front());
            if (b_iv && b_ir) void'(b_win.pop_front());
            if (d_iv && d_ir) void'(d_win.pop_front());
            if (e_iv && e_ir) void'(e_win.pop_front());
            if (c_ov && c_or) begin
                c_pop++;
                for (int l = 0; l < 3; l++) begin
                    w = '0;
                    for (int b = 0; b < 4; b++) w[b] = cq[l].size() > 0 ? cq[l].pop_front() : 1'b0;
                    check("c_lane", 64'(c_od[l*4 +: 4]), 64'(w));
                end
            end
            if (c_iv && c_ir) begin
                c_push++;
                for (int l = 0; l < 3; l++)
                    for (int b = 0; b < 10; b++) cq[l].push_back(c_in[l*10 + b]);
            end
            step();
        end
        a_iv = 0; b_iv = 0; d_iv = 0; e_iv = 0;
    endtask

    initial begin
        txrst = 1'b1;
        {a_iv, a_or, a_fl, b_iv, b_or, c_iv, c_or, d_iv, d_or, e_iv, e_or} = '0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0; e_in = '0;
        c_push = 0; c_pop = 0;
        repeat (2) @(posedge pclk);
        #1 txrst = 1'b0;
        check("rst_in_ready", 64'(a_ir), 64'd1);
        check("rst_out_valid", 64'(a_ov), 64'd0);
        check("rst_out_data", 64'(a_od), 64'd0);
        check("rst_fill", 64'(a_fill), 64'd0);

        // LSB-first, MSB-first and the 8/8 and 3/7 sweeps run side by side
        a_or = 1; a_win = '{64'h3FF, 64'h000}; a_exp = '{64'hF, 64'hF, 64'h3, 64'h0, 64'h0};
        b_or = 1; b_win = '{64'h200, 64'h000}; b_exp = '{64'h8, 64'h0, 64'h0, 64'h0, 64'h0};
        d_or = 1; d_win = '{64'hA5, 64'h3C, 64'hFF}; d_exp = '{64'hA5, 64'h3C, 64'hFF};
        e_or = 1; e_win = '{64'h5, 64'h3, 64'h6, 64'h1, 64'h7}; e_exp = '{64'h1D, 64'h67};
        cycle(9);
        check("lsb_out_valid", 64'(a_ov), 64'd0);
        check("lsb_fill", 64'(a_fill), 64'd0);
        check("lsb_missing", 64'(a_exp.size()), 64'd0);
        check("msb_fill", 64'(b_fill), 64'd0);
        check("msb_missing", 64'(b_exp.size()), 64'd0);
        check("w8_fill", 64'(d_fill), 64'd0);
        check("w8_missing", 64'(d_exp.size()), 64'd0);
        check("w3_fill", 64'(e_fill), 64'd1);
        check("w3_out_valid", 64'(e_ov), 64'd0);
        check("w3_missing", 64'(e_exp.size()), 64'd0);

        // Back-pressure: only one word fits while nothing drains
        a_or = 0; a_win = '{64'h2AB, 64'h154}; a_exp = '{64'hB, 64'hA, 64'h2, 64'h5, 64'h5};
        cycle(1);
        check("bp_fill", 64'(a_fill), 64'd10);
        check("bp_in_ready", 64'(a_ir), 64'd0);
        cycle(3);
        check("bp_fill_hold", 64'(a_fill), 64'd10);
        check("bp_in_ready_hold", 64'(a_ir), 64'd0);
        check("bp_out_valid", 64'(a_ov), 64'd1);
        a_or = 1;
        cycle(10);
        check("bp_missing", 64'(a_exp.size()), 64'd0);
        check("bp_fill_end", 64'(a_fill), 64'd0);

        // Flush at fill 6 while a push and a pop are both offered
        a_or = 0; a_win = '{64'h155};
        cycle(1);
        a_or = 1; a_exp = '{64'h5};
        cycle(1);
        check("fl_fill_before", 64'(a_fill), 64'd6);
        a_fl = 1; a_iv = 1; a_in = 10'h0AA;
        step();
        a_fl = 0; a_iv = 0;
        check("fl_fill", 64'(a_fill), 64'd0);
        check("fl_out_valid", 64'(a_ov), 64'd0);
        a_win = '{64'h3C1, 64'h000}; a_exp = '{64'h1, 64'hC, 64'h3, 64'h0, 64'h0};
        cycle(9);
        check("fl_missing", 64'(a_exp.size()), 64'd0);

        // Async reset mid-stream with 8 bits buffered
        a_or = 0; a_win = '{64'h3FF};
        cycle(1);
        a_or = 1; a_exp = '{64'hF, 64'hF};
        cycle(2);
        a_win = '{64'h000};
        cycle(1);
        a_exp = '{64'h3};
        cycle(1);
        a_or = 0;
        check("ar_fill_before", 64'(a_fill), 64'd8);
        #2 txrst = 1'b1;
        #1;
        check("ar_out_valid", 64'(a_ov), 64'd0);
        check("ar_in_ready", 64'(a_ir), 64'd1);
        check("ar_fill", 64'(a_fill), 64'd0);
        check("ar_out_data", 64'(a_od), 64'd0);
        #1 txrst = 1'b0;
        a_win.delete(); a_exp.delete();

        // Three-lane streaming against a per-lane bitstream model
        for (int l = 0; l < 3; l++) cq[l].delete();
        c_iv = 1; c_or = 1;
        cycle(9);
        c_push = 0; c_pop = 0;
        cycle(60);
        check("str_pushes", 64'(c_push), 64'd20);
        check("str_pops", 64'(c_pop), 64'd50);
        c_iv = 0;
        cycle(6);
        check("str_out_valid", 64'(c_ov), 64'd0);
        check("str_fill", 64'(c_fill), 64'(cq[0].size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
